// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, request legality.
package mem_access_ctrl_pkg;

  localparam int unsigned DEF_MEM_WORDS = 1024;
  localparam int unsigned XLEN          = 32;
  localparam int unsigned F3_W_BITS     = 3;

  localparam logic [F3_W_BITS-1:0] F3_B  = 3'b000;
  localparam logic [F3_W_BITS-1:0] F3_H  = 3'b001;
  localparam logic [F3_W_BITS-1:0] F3_W  = 3'b010;
  localparam logic [F3_W_BITS-1:0] F3_BU = 3'b100;
  localparam logic [F3_W_BITS-1:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RESP    = 3'd2,
    WR      = 3'd3,
    RMW_RD  = 3'd4,
    RMW_MRG = 3'd5,
    RMW_WR  = 3'd6,
    DONE    = 3'd7
  } state_e;

  // Illegal funct3 or misaligned offset; the address range is checked separately.
  function automatic logic req_bad(input logic we, input logic [F3_W_BITS-1:0] f3,
                                   input logic [1:0] off);
    logic bad;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = off[0];
      F3_W:    bad = (off != 2'b00);
      F3_BU:   bad = we;
      F3_HU:   bad = we | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational byte/half lane handling: load extract+extend and store merge.
module byte_lane_unit
  import mem_access_ctrl_pkg::*;
(
  input  logic [F3_W_BITS-1:0] f3,
  input  logic [1:0]           off,
  input  logic [XLEN-1:0]      mem_do,
  input  logic [15:0]          wdata,
  output logic [XLEN-1:0]      load_c,
  output logic [XLEN-1:0]      merge_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane and extend it for loads.
  always_comb begin
    case (off)
      2'd0:    byte_sel = mem_do[7:0];
      2'd1:    byte_sel = mem_do[15:8];
      2'd2:    byte_sel = mem_do[23:16];
      default: byte_sel = mem_do[31:24];
    endcase
    half_sel = off[1] ? mem_do[31:16] : mem_do[15:0];
    case (f3)
      F3_B:    load_c = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_c = {24'b0, byte_sel};
      F3_H:    load_c = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_c = {16'b0, half_sel};
      default: load_c = mem_do;
    endcase
  end

  // Replace the addressed byte (SB) or half (SH) of the read word with store data.
  always_comb begin
    merge_c = mem_do;
    if (f3[0]) begin
      if (off[1]) merge_c[31:16] = wdata;
      else        merge_c[15:0]  = wdata;
    end else begin
      case (off)
        2'd0:    merge_c[7:0]   = wdata[7:0];
        2'd1:    merge_c[15:8]  = wdata[7:0];
        2'd2:    merge_c[23:16] = wdata[7:0];
        default: merge_c[31:24] = wdata[7:0];
      endcase
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store unit: byte-addressed RV32I loads/stores onto a word-addressed memory port.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ,
  input  logic                 REQ_WE,
  input  logic [F3_W_BITS-1:0] REQ_F3,
  input  logic [XLEN-1:0]      REQ_ADDR,
  input  logic [XLEN-1:0]      REQ_WDATA,
  output logic                 BUSY,
  output logic                 ACK,
  output logic                 ERR,
  output logic [XLEN-1:0]      RDATA,
  output logic [XLEN-1:0]      MEM_ADDR,
  output logic [XLEN-1:0]      MEM_DIN,
  output logic                 MEM_WE,
  input  logic [XLEN-1:0]      MEM_DO,
  input  logic                 MEM_RDY
);

  state_e                state_q, state_d;
  logic [F3_W_BITS-1:0]  f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic [XLEN-1:0]       rdata_q, rdata_d;
  logic [XLEN-1:0]       mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]       mem_din_q, mem_din_d;
  logic                  mem_we_q, mem_we_d;

  logic [XLEN-1:0]       load_c;
  logic [XLEN-1:0]       merge_c;
  logic                  out_of_range_c;

  byte_lane_unit u_lane (
    .f3      (f3_q),
    .off     (off_q),
    .mem_do  (MEM_DO),
    .wdata   (wdata_q),
    .load_c  (load_c),
    .merge_c (merge_c)
  );

  assign out_of_range_c = ({2'b00, REQ_ADDR[XLEN-1:2]} >= XLEN'(MEM_WORDS));

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    f3_d       = f3_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    ack_d      = 1'b0;
    rdata_d    = rdata_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = mem_we_q;
    case (state_q)
      IDLE: begin
        if (REQ) begin
          f3_d    = REQ_F3;
          off_d   = REQ_ADDR[1:0];
          wdata_d = REQ_WDATA[15:0];
          if (req_bad(REQ_WE, REQ_F3, REQ_ADDR[1:0]) || out_of_range_c) begin
            err_d   = 1'b1;
            ack_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d      = 1'b0;
            mem_addr_d = {2'b00, REQ_ADDR[XLEN-1:2]};
            mem_din_d  = REQ_WDATA;
            if (!REQ_WE) begin
              state_d = RD;
            end else if (REQ_F3 == F3_W) begin
              mem_we_d = 1'b1;
              state_d  = WR;
            end else begin
              state_d = RMW_RD;
            end
          end
        end
      end
      RD: begin
        if (MEM_RDY) state_d = RESP;
      end
      RESP: begin
        rdata_d = load_c;
        ack_d   = 1'b1;
        state_d = DONE;
      end
      RMW_RD: begin
        if (MEM_RDY) state_d = RMW_MRG;
      end
      RMW_MRG: begin
        mem_din_d = merge_c;
        mem_we_d  = 1'b1;
        state_d   = RMW_WR;
      end
      WR, RMW_WR: begin
        if (MEM_RDY) begin
          mem_we_d = 1'b0;
          ack_d    = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      f3_q       <= '0;
      off_q      <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      rdata_q    <= rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
    end
  end

  assign BUSY     = busy_q;
  assign ACK      = ack_q;
  assign ERR      = err_q;
  assign RDATA    = rdata_q;
  assign MEM_ADDR = mem_addr_q;
  assign MEM_DIN  = mem_din_q;
  // Write enable is masked during reset so a reset edge never commits a store.
  assign MEM_WE   = mem_we_q & ~RST;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a word memory model preloaded to word i = 2*i.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_f3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        busy, ack, err, mem_we;
  logic [31:0] rdata, mem_addr, mem_din;
  logic [31:0] mem_do = 32'h0;
  logic        mem_rdy = 1'b1;

  logic [31:0] mem [0:1023];
  int          cyc = 0;
  int          commits = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_rdata = 32'h0;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    int          ack_cyc;
  } exp_t;
  exp_t sb[$];

  mem_access_ctrl dut (
    .CLK       (clk),
    .RST       (rst),
    .REQ       (req),
    .REQ_WE    (req_we),
    .REQ_F3    (req_f3),
    .REQ_ADDR  (req_addr),
    .REQ_WDATA (req_wdata),
    .BUSY      (busy),
    .ACK       (ack),
    .ERR       (err),
    .RDATA     (rdata),
    .MEM_ADDR  (mem_addr),
    .MEM_DIN   (mem_din),
    .MEM_WE    (mem_we),
    .MEM_DO    (mem_do),
    .MEM_RDY   (mem_rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Word memory: registered read, write on ready edges; it does not see reset.
  always @(posedge clk) begin
    if (mem_rdy && mem_addr < 32'd1024) begin
      mem_do <= mem[mem_addr[9:0]];
      if (mem_we) begin
        mem[mem_addr[9:0]] <= mem_din;
        commits <= commits + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ACK pops the oldest expectation and compares ERR, RDATA and timing.
  always @(negedge clk) begin
    if (!rst && ack === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(ack), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_err"}, 32'(err), 32'(e.err));
        check({e.name, "_rdata"}, rdata, e.rdata);
        check({e.name, "_ack_cycle"}, 32'(cyc), 32'(e.ack_cyc));
      end
    end
  end

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1'b1;
    end
    if (!ok) check({name, "_idle_timeout"}, 32'(busy), 32'h0);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check({name, "_drained"}, 32'(sb.size()), 32'h0);
  endtask

  // Issue one request at a negedge; lat = cycles from accept edge to ACK cycle.
  task automatic issue(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_rd, input int lat);
    exp_t e;
    wait_idle(name);
    req = 1'b1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0;
    if (!exp_err && !we) last_rdata = exp_rd;
    e.name = name; e.err = exp_err; e.rdata = last_rdata; e.ack_cyc = cyc + lat - 1;
    sb.push_back(e);
    wait_drain(name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_ack"}, 32'(ack), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_din"}, mem_din, 32'h0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int c0;
    exp_t e;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(2 * i);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Basic loads/stores
    issue("lw_14",  1'b0, 3'b010, 32'h14, 32'h0,        1'b0, 32'h0000000A, 3);
    issue("sw_8",   1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 1'b0, 32'h0,        2);
    issue("lb_8",   1'b0, 3'b000, 32'h08, 32'h0,        1'b0, 32'hFFFFFFEF, 3);
    issue("lbu_b",  1'b0, 3'b100, 32'h0B, 32'h0,        1'b0, 32'h000000DE, 3);

    c0 = commits;
    issue("sh_12",  1'b1, 3'b001, 32'h12, 32'h00001234, 1'b0, 32'h0,        4);
    check("sh_12_write_count", 32'(commits - c0), 32'h1);
    issue("lw_10",  1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'h12340008, 3);
    issue("lh_12",  1'b0, 3'b001, 32'h12, 32'h0,        1'b0, 32'h00001234, 3);

    issue("sb_17",  1'b1, 3'b000, 32'h17, 32'hFFFFFF80, 1'b0, 32'h0,        4);
    issue("lb_17",  1'b0, 3'b000, 32'h17, 32'h0,        1'b0, 32'hFFFFFF80, 3);
    issue("lhu_16", 1'b0, 3'b101, 32'h16, 32'h0,        1'b0, 32'h00008000, 3);
    issue("lh_16",  1'b0, 3'b001, 32'h16, 32'h0,        1'b0, 32'hFFFF8000, 3);

    // Rejected requests never touch memory and leave RDATA alone
    c0 = commits;
    issue("lh_3_mis",    1'b0, 3'b001, 32'h03,   32'h0, 1'b1, 32'h0, 1);
    issue("lw_1002_oor", 1'b0, 3'b010, 32'h1002, 32'h0, 1'b1, 32'h0, 1);
    issue("f3_011",      1'b0, 3'b011, 32'h00,   32'h0, 1'b1, 32'h0, 1);
    issue("sbu_illegal", 1'b1, 3'b100, 32'h04,   32'h0, 1'b1, 32'h0, 1);
    issue("sw_oor",      1'b1, 3'b010, 32'hFFC,  32'h1, 1'b0, 32'h0, 2);
    issue("sw_oor_2",    1'b1, 3'b010, 32'h1000, 32'h1, 1'b1, 32'h0, 1);
    check("err_write_count", 32'(commits - c0), 32'h1);

    // SW with three not-ready cycles; REQ pulses while busy must be ignored
    wait_idle("sw_stall");
    c0 = commits;
    req = 1'b1; req_we = 1'b1; req_f3 = 3'b010; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req = 1'b0;
    mem_rdy = 1'b0;
    e.name = "sw_stall"; e.err = 1'b0; e.rdata = last_rdata; e.ack_cyc = cyc + 4;
    sb.push_back(e);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_mem_addr", mem_addr, 32'h10);
      check("stall_mem_din", mem_din, 32'hCAFEF00D);
      check("stall_mem_we", 32'(mem_we), 32'h1);
      check("stall_busy", 32'(busy), 32'h1);
      req = 1'b1; req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h0;
      @(posedge clk);
      #1;
    end
    mem_rdy = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_drain("sw_stall");
    check("sw_stall_write_count", 32'(commits - c0), 32'h1);
    issue("lw_40",  1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'hCAFEF00D, 3);

    // Reset during RMW_WR of an SB abandons it with no write and no ACK
    wait_idle("sb_reset");
    c0 = commits;
    req = 1'b1; req_we = 1'b1; req_f3 = 3'b000; req_addr = 32'h20; req_wdata = 32'h55;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rmw_wr_mem_we", 32'(mem_we), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_reset");
    check("mid_reset_write_count", 32'(commits - c0), 32'h0);
    rst = 1'b0;
    last_rdata = 32'h0;
    issue("lw_20_after_reset", 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h00000010, 3);

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
